// File: rtl/raster_pkg.sv
// Shared definitions for the raster sequencer slice.
//   - seq_state_e : sequencer FSM state encoding
//   - *_DEF       : default coordinate / depth / color widths
//   - pix_rec_w   : width of one {x, y, depth, color} pixel record
package raster_pkg;

    localparam int unsigned COORD_W_DEF = 16;
    localparam int unsigned DEPTH_W_DEF = 2;
    localparam int unsigned COLOR_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BOUNDS,
        ST_EDGES,
        ST_SETUP,
        ST_RASTER,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    function automatic int unsigned pix_rec_w(input int unsigned coord_w,
                                              input int unsigned depth_w,
                                              input int unsigned color_w);
        return 2 * coord_w + depth_w + color_w;
    endfunction

    localparam int unsigned PIX_W_DEF = pix_rec_w(COORD_W_DEF, DEPTH_W_DEF, COLOR_W_DEF);

endpackage

// File: rtl/pixel_fifo2.sv
// Two-entry pixel FIFO between the rasterizer and the framebuffer writer.
// Ports:
//   clock, reset_n  : clock, asynchronous active-low reset
//   push_i, din_i   : write request and record
//   pop_i           : read request (ignored when empty)
//   dout_o          : head record
//   count_o         : occupancy 0..2
//   full_o, empty_o : occupancy flags
//   overflow_o      : push refused this cycle (full, no pop)
module pixel_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic [1:0]   count_o,
    output logic         full_o,
    output logic         empty_o,
    output logic         overflow_o
);

    logic [W-1:0] e0_q, e0_d;   // head
    logic [W-1:0] e1_q, e1_d;
    logic [1:0]   count_q, count_d;
    logic         pop_ok;
    logic         push_ok;

    // A push into a full FIFO is accepted only if the head leaves in the same cycle.
    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10: begin
                if (count_q == 2'd0) e0_d = din_i;
                else                 e1_d = din_i;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                e0_d    = e1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    e0_d = din_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= '0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign dout_o     = e0_q;
    assign count_o    = count_q;
    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign overflow_o = push_i && !push_ok;

endmodule

// File: rtl/raster_sequencer.sv
// Sequences one triangle at a time through the rasterizer steps and buffers
// rasterized pixels toward the framebuffer writer.
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   tri_valid/tri_ready, tri_*: triangle request and its vertices/depths/color
//   ras_<step>                : one-cycle step controls to the rasterizer
//   ras_rasterize_pixels      : rasterizer may produce a pixel this cycle
//   ras_v*/ras_d*/ras_color   : latched triangle presented to the rasterizer
//   ras_write_pixel, ras_pix_*: pixel produced by the rasterizer
//   ras_done                  : rasterizer finished the triangle
//   pix_valid/pix_ready, pix_*: pixel stream to the framebuffer writer
//   tri_done                  : one-cycle pulse per finished triangle
//   err_timeout, err_overflow : sticky error flags
module raster_sequencer
    import raster_pkg::*;
#(
    parameter int unsigned COORD_W     = COORD_W_DEF,
    parameter int unsigned DEPTH_W     = DEPTH_W_DEF,
    parameter int unsigned COLOR_W     = COLOR_W_DEF,
    parameter int unsigned WDOG_CYCLES = 65535
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [COORD_W-1:0] tri_v0x, tri_v0y, tri_v1x, tri_v1y, tri_v2x, tri_v2y,
    input  logic [DEPTH_W-1:0] tri_d0, tri_d1, tri_d2,
    input  logic [COLOR_W-1:0] tri_color,
    output logic               ras_start_new_triangle,
    output logic               ras_get_boundary_coords,
    output logic               ras_form_edges,
    output logic               ras_pixel_loop_setup,
    output logic               ras_rasterize_pixels,
    output logic [COORD_W-1:0] ras_v0x, ras_v0y, ras_v1x, ras_v1y, ras_v2x, ras_v2y,
    output logic [DEPTH_W-1:0] ras_d0, ras_d1, ras_d2,
    output logic [COLOR_W-1:0] ras_color,
    input  logic               ras_write_pixel,
    input  logic               ras_done,
    input  logic [COORD_W-1:0] ras_pix_x, ras_pix_y,
    input  logic [DEPTH_W-1:0] ras_pix_depth,
    input  logic [COLOR_W-1:0] ras_pix_color,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x, pix_y,
    output logic [DEPTH_W-1:0] pix_depth,
    output logic [COLOR_W-1:0] pix_color,
    output logic               tri_done,
    output logic               err_timeout,
    output logic               err_overflow
);

    localparam int unsigned PIX_W    = pix_rec_w(COORD_W, DEPTH_W, COLOR_W);
    localparam logic [15:0] WDOG_LIM = 16'(WDOG_CYCLES);

    seq_state_e         state_q, state_d;
    logic [15:0]        wdog_q;
    logic               wdog_hit;
    logic               tri_ready_q, start_q, bounds_q, edges_q, setup_q, tri_done_q;
    logic               err_timeout_q, err_overflow_q;
    logic [COORD_W-1:0] v0x_q, v0y_q, v1x_q, v1y_q, v2x_q, v2y_q;
    logic [DEPTH_W-1:0] d0_q, d1_q, d2_q;
    logic [COLOR_W-1:0] color_q;

    logic [PIX_W-1:0]   fifo_dout;
    logic [1:0]         fifo_count;
    logic               fifo_full, fifo_empty, fifo_ovf;

    pixel_fifo2 #(.W(PIX_W)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (ras_write_pixel),
        .pop_i      (pix_ready),
        .din_i      ({ras_pix_x, ras_pix_y, ras_pix_depth, ras_pix_color}),
        .dout_o     (fifo_dout),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_ovf)
    );

    // Fires in the RASTER cycle whose count reaches the limit.
    assign wdog_hit = (state_q == ST_RASTER) && ((wdog_q + 16'd1) == WDOG_LIM);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (tri_valid) state_d = ST_START;
            ST_START:  state_d = ST_BOUNDS;
            ST_BOUNDS: state_d = ST_EDGES;
            ST_EDGES:  state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_RASTER;
            ST_RASTER: if (ras_done || wdog_hit) state_d = ST_DRAIN;
            ST_DRAIN:  if (fifo_count == 2'd0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Step controls are decoded from the next state so they are registered
    // yet line up exactly with the state they belong to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tri_ready_q    <= 1'b1;
            start_q        <= 1'b0;
            bounds_q       <= 1'b0;
            edges_q        <= 1'b0;
            setup_q        <= 1'b0;
            tri_done_q     <= 1'b0;
            wdog_q         <= '0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            v0x_q <= '0; v0y_q <= '0; v1x_q <= '0; v1y_q <= '0; v2x_q <= '0; v2y_q <= '0;
            d0_q  <= '0; d1_q  <= '0; d2_q  <= '0;
            color_q <= '0;
        end else begin
            state_q     <= state_d;
            tri_ready_q <= (state_d == ST_IDLE);
            start_q     <= (state_d == ST_START);
            bounds_q    <= (state_d == ST_BOUNDS);
            edges_q     <= (state_d == ST_EDGES);
            setup_q     <= (state_d == ST_SETUP);
            tri_done_q  <= (state_d == ST_DONE);
            if (state_q == ST_IDLE && tri_valid) begin
                v0x_q <= tri_v0x; v0y_q <= tri_v0y;
                v1x_q <= tri_v1x; v1y_q <= tri_v1y;
                v2x_q <= tri_v2x; v2y_q <= tri_v2y;
                d0_q  <= tri_d0;  d1_q  <= tri_d1;  d2_q <= tri_d2;
                color_q <= tri_color;
            end
            if (state_q == ST_SETUP)       wdog_q <= '0;
            else if (state_q == ST_RASTER) wdog_q <= wdog_q + 16'd1;
            if (wdog_hit) err_timeout_q  <= 1'b1;
            if (fifo_ovf) err_overflow_q <= 1'b1;
        end
    end

    // Allow a new pixel only if it is guaranteed a FIFO slot next cycle.
    assign ras_rasterize_pixels = (state_q == ST_RASTER) &&
                                  (fifo_empty || (!fifo_full && pix_ready));

    assign tri_ready               = tri_ready_q;
    assign ras_start_new_triangle  = start_q;
    assign ras_get_boundary_coords = bounds_q;
    assign ras_form_edges          = edges_q;
    assign ras_pixel_loop_setup    = setup_q;
    assign tri_done                = tri_done_q;
    assign err_timeout             = err_timeout_q;
    assign err_overflow            = err_overflow_q;

    assign ras_v0x = v0x_q; assign ras_v0y = v0y_q;
    assign ras_v1x = v1x_q; assign ras_v1y = v1y_q;
    assign ras_v2x = v2x_q; assign ras_v2y = v2y_q;
    assign ras_d0  = d0_q;  assign ras_d1  = d1_q;  assign ras_d2 = d2_q;
    assign ras_color = color_q;

    assign pix_valid = !fifo_empty;
    assign {pix_x, pix_y, pix_depth, pix_color} = fifo_dout;

endmodule

// File: tb/tb_raster_sequencer.sv
module tb_raster_sequencer;

    localparam int CW   = 16;
    localparam int DW   = 2;
    localparam int CLW  = 16;
    localparam int WDOG = 16;

    typedef logic [2*CW+DW+CLW-1:0] pix_t;

    logic clock = 1'b0;
    logic reset_n;
    logic tri_valid, tri_ready;
    logic [CW-1:0]  tri_v0x, tri_v0y, tri_v1x, tri_v1y, tri_v2x, tri_v2y;
    logic [DW-1:0]  tri_d0, tri_d1, tri_d2;
    logic [CLW-1:0] tri_color;
    logic ras_start_new_triangle, ras_get_boundary_coords, ras_form_edges;
    logic ras_pixel_loop_setup, ras_rasterize_pixels;
    logic [CW-1:0]  ras_v0x, ras_v0y, ras_v1x, ras_v1y, ras_v2x, ras_v2y;
    logic [DW-1:0]  ras_d0, ras_d1, ras_d2;
    logic [CLW-1:0] ras_color;
    logic ras_write_pixel, ras_done;
    logic [CW-1:0]  ras_pix_x, ras_pix_y;
    logic [DW-1:0]  ras_pix_depth;
    logic [CLW-1:0] ras_pix_color;
    logic pix_valid, pix_ready;
    logic [CW-1:0]  pix_x, pix_y;
    logic [DW-1:0]  pix_depth;
    logic [CLW-1:0] pix_color;
    logic tri_done, err_timeout, err_overflow;

    always #5 clock = ~clock;

    raster_sequencer #(
        .COORD_W(CW), .DEPTH_W(DW), .COLOR_W(CLW), .WDOG_CYCLES(WDOG)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready),
        .tri_v0x(tri_v0x), .tri_v0y(tri_v0y), .tri_v1x(tri_v1x),
        .tri_v1y(tri_v1y), .tri_v2x(tri_v2x), .tri_v2y(tri_v2y),
        .tri_d0(tri_d0), .tri_d1(tri_d1), .tri_d2(tri_d2), .tri_color(tri_color),
        .ras_start_new_triangle(ras_start_new_triangle),
        .ras_get_boundary_coords(ras_get_boundary_coords),
        .ras_form_edges(ras_form_edges),
        .ras_pixel_loop_setup(ras_pixel_loop_setup),
        .ras_rasterize_pixels(ras_rasterize_pixels),
        .ras_v0x(ras_v0x), .ras_v0y(ras_v0y), .ras_v1x(ras_v1x),
        .ras_v1y(ras_v1y), .ras_v2x(ras_v2x), .ras_v2y(ras_v2y),
        .ras_d0(ras_d0), .ras_d1(ras_d1), .ras_d2(ras_d2), .ras_color(ras_color),
        .ras_write_pixel(ras_write_pixel), .ras_done(ras_done),
        .ras_pix_x(ras_pix_x), .ras_pix_y(ras_pix_y),
        .ras_pix_depth(ras_pix_depth), .ras_pix_color(ras_pix_color),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_depth(pix_depth), .pix_color(pix_color),
        .tri_done(tri_done), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    int   tests_run = 0;
    int   failures  = 0;
    int   tri_done_seen = 0;
    pix_t exp_q[$];
    pix_t pix_bus;
    pix_t held;
    bit   stall = 1'b0;

    assign pix_bus = {pix_x, pix_y, pix_depth, pix_color};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctrl();
        return {ras_start_new_triangle, ras_get_boundary_coords, ras_form_edges,
                ras_pixel_loop_setup, ras_rasterize_pixels};
    endfunction

    function automatic pix_t mk(input logic [CW-1:0] x, input logic [CW-1:0] y,
                                input logic [DW-1:0] d, input logic [CLW-1:0] c);
        return {x, y, d, c};
    endfunction

    // Scoreboard monitor: every accepted pixel must match the oldest expected
    // one; a stalled head must not change.
    always @(negedge clock) begin
        if (!reset_n) begin
            stall <= 1'b0;
        end else begin
            if (tri_done) tri_done_seen <= tri_done_seen + 1;
            if (stall) begin
                chk("pix_hold_valid", 64'(pix_valid), 64'd1);
                chk("pix_hold_data", 64'(pix_bus), 64'(held));
            end
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    failures++;
                    $display("FAIL pix_unexpected: got %0h expected no pixel", pix_bus);
                end else begin
                    chk("pix_data", 64'(pix_bus), 64'(exp_q.pop_front()));
                end
            end
            stall <= pix_valid && !pix_ready;
            held  <= pix_bus;
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        tri_valid       = 1'b0;
        ras_write_pixel = 1'b0;
        ras_done        = 1'b0;
    endtask

    task automatic write_pix(input pix_t p, input bit keep);
        ras_write_pixel = 1'b1;
        {ras_pix_x, ras_pix_y, ras_pix_depth, ras_pix_color} = p;
        if (keep) exp_q.push_back(p);
    endtask

    task automatic set_tri(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                           input logic [CW-1:0] x1, input logic [CW-1:0] y1,
                           input logic [CW-1:0] x2, input logic [CW-1:0] y2,
                           input logic [CLW-1:0] col);
        tri_v0x = x0; tri_v0y = y0; tri_v1x = x1; tri_v1y = y1;
        tri_v2x = x2; tri_v2y = y2; tri_color = col;
        tri_d0 = 2'd1; tri_d1 = 2'd2; tri_d2 = 2'd3;
    endtask

    // Cycle 0 accept through cycle 4 (SETUP); returns at the start of cycle 5.
    task automatic accept_tri(input string tag,
                              input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                              input logic [CW-1:0] x1, input logic [CW-1:0] y1,
                              input logic [CW-1:0] x2, input logic [CW-1:0] y2,
                              input logic [CLW-1:0] col);
        set_tri(x0, y0, x1, y1, x2, y2, col);
        tri_valid = 1'b1;
        sample();
        chk({tag, "_c0_ready"}, 64'(tri_ready), 64'd1);
        chk({tag, "_c0_ctrl"}, 64'(ctrl()), 64'b00000);
        next_cycle();
        tri_valid = 1'b0;
        set_tri(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'h5555);
        sample();
        chk({tag, "_c1_start"}, 64'(ctrl()), 64'b10000);
        chk({tag, "_c1_ready"}, 64'(tri_ready), 64'd0);
        chk({tag, "_v0x"}, 64'(ras_v0x), 64'(x0));
        chk({tag, "_v1y"}, 64'(ras_v1y), 64'(y1));
        chk({tag, "_v2x"}, 64'(ras_v2x), 64'(x2));
        chk({tag, "_depths"}, 64'({ras_d0, ras_d1, ras_d2}), 64'b01_10_11);
        chk({tag, "_color"}, 64'(ras_color), 64'(col));
        next_cycle();
        sample();
        chk({tag, "_c2_bounds"}, 64'(ctrl()), 64'b01000);
        next_cycle();
        sample();
        chk({tag, "_c3_edges"}, 64'(ctrl()), 64'b00100);
        next_cycle();
        sample();
        chk({tag, "_c4_setup"}, 64'(ctrl()), 64'b00010);
        next_cycle();
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            sample();
            if (tri_done) seen = 1'b1;
            else          next_cycle();
        end
        chk({tag, "_tri_done"}, 64'(seen), 64'd1);
        if (seen) begin
            next_cycle();
            sample();
            chk({tag, "_done_pulse"}, 64'({tri_done, tri_ready}), 64'b01);
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit left;
        idle_inputs();
        pix_ready = 1'b1;
        set_tri('0, '0, '0, '0, '0, '0, '0);
        {ras_pix_x, ras_pix_y, ras_pix_depth, ras_pix_color} = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        sample();
        chk("reset_outputs", 64'({tri_ready, ctrl(), tri_done, pix_valid, err_timeout, err_overflow}),
            64'b1_00000_0_0_0_0);
        chk("reset_latched", 64'({ras_v0x, ras_color}), 64'd0);
        next_cycle();

        // Basic triangle, free-flowing output.
        accept_tri("t1", 100, 25, 125, 75, 75, 75, 16'hFF00);
        write_pix(mk(100, 25, 1, 16'hFF00), 1'b1);
        sample();
        chk("t1_c5_raster", 64'(ctrl()), 64'b00001);
        next_cycle();
        write_pix(mk(101, 26, 2, 16'hFF00), 1'b1);
        sample();
        chk("t1_c6_raster_cnt1", 64'({ras_rasterize_pixels, pix_valid}), 64'b11);
        next_cycle();
        write_pix(mk(102, 27, 3, 16'hFF00), 1'b1);
        ras_done = 1'b1;
        next_cycle();
        idle_inputs();
        sample();
        chk("t1_drain_ctrl", 64'(ctrl()), 64'b00000);
        next_cycle();
        wait_done("t1", 10);

        // Output stalled for 10 cycles while the FIFO fills.
        accept_tri("t2", 10, 20, 30, 40, 50, 60, 16'h1234);
        pix_ready = 1'b0;
        write_pix(mk(11, 21, 0, 16'h1234), 1'b1);
        sample();
        chk("t2_c5_raster", 64'(ras_rasterize_pixels), 64'd1);
        next_cycle();
        write_pix(mk(12, 22, 1, 16'h1234), 1'b1);
        sample();
        chk("t2_c6_raster_blocked", 64'(ras_rasterize_pixels), 64'd0);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 8; i++) begin
            sample();
            chk("t2_stall_ctrl", 64'({ras_rasterize_pixels, pix_valid}), 64'b01);
            chk("t2_stall_head", 64'(pix_bus), 64'(mk(11, 21, 0, 16'h1234)));
            next_cycle();
        end
        pix_ready = 1'b1;
        sample();
        chk("t2_full_ready", 64'(ras_rasterize_pixels), 64'd0);
        next_cycle();
        ras_done = 1'b1;
        sample();
        chk("t2_cnt1_ready", 64'(ras_rasterize_pixels), 64'd1);
        next_cycle();
        idle_inputs();
        wait_done("t2", 10);
        chk("t2_no_timeout", 64'({err_timeout, err_overflow}), 64'b00);

        // ras_done together with a final write while one pixel is queued.
        accept_tri("t3", 200, 5, 210, 15, 190, 15, 16'h0F0F);
        pix_ready = 1'b0;
        write_pix(mk(200, 5, 1, 16'h0F0F), 1'b1);
        next_cycle();
        pix_ready = 1'b1;
        write_pix(mk(201, 6, 2, 16'h0F0F), 1'b1);
        ras_done = 1'b1;
        sample();
        chk("t3_cnt1_raster", 64'(ras_rasterize_pixels), 64'd1);
        next_cycle();
        idle_inputs();
        wait_done("t3", 10);

        // Forced write into a full FIFO is dropped.
        accept_tri("t4", 1, 2, 3, 4, 5, 6, 16'hABCD);
        pix_ready = 1'b0;
        write_pix(mk(1, 1, 0, 16'hA001), 1'b1);
        next_cycle();
        write_pix(mk(2, 2, 1, 16'hA002), 1'b1);
        next_cycle();
        write_pix(mk(3, 3, 2, 16'hA003), 1'b0);
        sample();
        chk("t4_ovf_before", 64'(err_overflow), 64'd0);
        next_cycle();
        idle_inputs();
        sample();
        chk("t4_ovf_set", 64'(err_overflow), 64'd1);
        chk("t4_head_kept", 64'(pix_bus), 64'(mk(1, 1, 0, 16'hA001)));
        next_cycle();
        pix_ready = 1'b1;
        ras_done  = 1'b1;
        next_cycle();
        idle_inputs();
        wait_done("t4", 10);
        chk("t4_ovf_sticky", 64'(err_overflow), 64'd1);

        // Rasterizer never finishes: watchdog ends the triangle.
        accept_tri("t5", 7, 7, 9, 9, 7, 9, 16'h7777);
        n = 0;
        left = 1'b0;
        for (int i = 0; i < 40 && !left; i++) begin
            sample();
            if (ras_rasterize_pixels) n++;
            else                      left = 1'b1;
            if (!left) next_cycle();
        end
        chk("t5_raster_cycles", 64'(n), 64'(WDOG));
        chk("t5_err_timeout", 64'(err_timeout), 64'd1);
        next_cycle();
        wait_done("t5", 10);

        // Reset during EDGES, then a normal triangle.
        set_tri(40, 40, 60, 80, 20, 80, 16'hBEEF);
        tri_valid = 1'b1;
        next_cycle();
        tri_valid = 1'b0;
        next_cycle();
        next_cycle();
        sample();
        chk("t6_in_edges", 64'(ctrl()), 64'b00100);
        #1 reset_n = 1'b0;
        #1;
        chk("t6_reset_outputs", 64'({tri_ready, ctrl(), tri_done, pix_valid, err_timeout, err_overflow}),
            64'b1_00000_0_0_0_0);
        chk("t6_reset_latched", 64'({ras_v0x, ras_color}), 64'd0);
        #2 reset_n = 1'b1;
        next_cycle();
        accept_tri("t7", 300, 310, 320, 330, 340, 350, 16'hC0DE);
        write_pix(mk(305, 315, 3, 16'hC0DE), 1'b1);
        ras_done = 1'b1;
        sample();
        chk("t7_c5_raster", 64'(ctrl()), 64'b00001);
        next_cycle();
        idle_inputs();
        wait_done("t7", 10);

        chk("pix_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("tri_done_total", 64'(tri_done_seen), 64'd6);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
